// File: rtl/count_pwm.sv
// PWM generator driven by a free-running upstream count, with a shadowed duty value loaded over valid/ready.
// Optional build macro COUNT_PWM_SEQ_CHECK_EN adds a sticky seq_err flag for count sequence errors.
module count_pwm #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [WIDTH:0]   duty_active,
    output logic             pwm_out,
    output logic             wrap
`ifdef COUNT_PWM_SEQ_CHECK_EN
    ,
    output logic             seq_err
`endif
);

    localparam logic [WIDTH:0]   DUTY_MAX   = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] COUNT_LAST = {WIDTH{1'b1}};

    // Pending-slot state; duty_ready is this state decoded straight from the register.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    slot_t          slot_state;
    logic [WIDTH:0] pending;
    logic [WIDTH:0] duty_sat;
    logic           at_last;

    // Handshake: a duty transfer happens on any rising edge where duty_valid && duty_ready;
    // duty_valid is ignored while the slot is full, and duty_ready never depends on duty_valid.
    assign duty_ready = (slot_state == SLOT_EMPTY);
    assign duty_sat   = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign at_last    = (count == COUNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_state  <= SLOT_EMPTY;
            pending     <= '0;
            duty_active <= '0;
            pwm_out     <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            // Compare uses the duty in force before this edge's shadow update.
            pwm_out <= en && ({1'b0, count} < duty_active);
            wrap    <= at_last;
            case (slot_state)
                SLOT_EMPTY: begin
                    if (duty_valid) begin
                        pending    <= duty_sat;
                        slot_state <= SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (at_last) begin
                        duty_active <= pending;
                        slot_state  <= SLOT_EMPTY;
                    end
                end
                default: slot_state <= SLOT_EMPTY;
            endcase
        end
    end

`ifdef COUNT_PWM_SEQ_CHECK_EN
    logic [WIDTH-1:0] prev_count;
    logic [WIDTH-1:0] next_expected;
    logic             prev_valid;

    assign next_expected = prev_count + 1'b1;

    // First edge after reset only seeds prev_count; checking starts on the one after.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_count <= '0;
            prev_valid <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev_count <= count;
            prev_valid <= 1'b1;
            if (prev_valid && (count != next_expected)) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    // Without the sequence checker no previous count is kept.
`endif

endmodule
